// File: rtl/npc_defs_pkg.sv
// Shared npc definitions: ALU op codes, base opcodes and funct7 patterns used by decode and EXU.
// Also holds the skid-buffer state type for the decode pipeline register.
package npc_defs_pkg;

  localparam int unsigned ALU_OP_W = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'h00;
  localparam logic [ALU_OP_W-1:0] ALU_LUI    = 5'h01;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'h02;
  localparam logic [ALU_OP_W-1:0] ALU_JALR   = 5'h03;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'h04;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'h05;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'h06;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'h07;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'h08;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'h09;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'h0A;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'h0C;
  localparam logic [ALU_OP_W-1:0] ALU_BEQ    = 5'h0D;
  localparam logic [ALU_OP_W-1:0] ALU_BGE    = 5'h0E;
  localparam logic [ALU_OP_W-1:0] ALU_BGEU   = 5'h0F;
  localparam logic [ALU_OP_W-1:0] ALU_BLT    = 5'h10;
  localparam logic [ALU_OP_W-1:0] ALU_BLTU   = 5'h11;
  localparam logic [ALU_OP_W-1:0] ALU_BNE    = 5'h12;
  localparam logic [ALU_OP_W-1:0] ALU_SLLI   = 5'h13;
  localparam logic [ALU_OP_W-1:0] ALU_SRAI   = 5'h14;
  localparam logic [ALU_OP_W-1:0] ALU_SRLI   = 5'h15;
  localparam logic [ALU_OP_W-1:0] ALU_CSRRS  = 5'h16;
  localparam logic [ALU_OP_W-1:0] ALU_CSRRW  = 5'h17;
  localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'h18;
  localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'h19;
  localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'h1A;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'h1B;
  localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'h1C;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'h1D;
  localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'h1E;
  localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'h1F;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I/Zicsr(/M) decoder: opcode/funct3/funct7 -> ALU op code plus illegal flag.
// Only the fields that select the operation are taken in; register and immediate bits are ignored.
module alu_ctrl_dec
  import npc_defs_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [ALU_OP_W-1:0] alu_ctrl,
  output logic                illegal
);

  logic [ALU_OP_W-1:0] op_sel;
  logic                bad;

  always_comb begin
    op_sel = ALU_ADD;
    bad    = 1'b0;
    case (opcode)
      OPC_LUI:   op_sel = ALU_LUI;
      OPC_AUIPC: op_sel = ALU_ADD;
      OPC_JAL:   op_sel = ALU_ADD;
      OPC_JALR: begin
        if (funct3 == 3'b000) op_sel = ALU_JALR;
        else                  bad    = 1'b1;
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_sel = ALU_ADD;
          default:                                bad    = 1'b1;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000, 3'b001, 3'b010: op_sel = ALU_ADD;
          default:                bad    = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  op_sel = ALU_BEQ;
          3'b001:  op_sel = ALU_BNE;
          3'b100:  op_sel = ALU_BLT;
          3'b101:  op_sel = ALU_BGE;
          3'b110:  op_sel = ALU_BLTU;
          3'b111:  op_sel = ALU_BGEU;
          default: bad    = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        // Shift-immediates reuse funct7 as the top of the immediate, so it must match exactly.
        case (funct3)
          3'b000: op_sel = ALU_ADD;
          3'b010: op_sel = ALU_SLT;
          3'b011: op_sel = ALU_SLTU;
          3'b100: op_sel = ALU_XOR;
          3'b110: op_sel = ALU_OR;
          3'b111: op_sel = ALU_AND;
          3'b001: begin
            if (funct7 == F7_BASE) op_sel = ALU_SLLI;
            else                   bad    = 1'b1;
          end
          default: begin
            if      (funct7 == F7_BASE) op_sel = ALU_SRLI;
            else if (funct7 == F7_ALT)  op_sel = ALU_SRAI;
            else                        bad    = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  op_sel = ALU_ADD;
            3'b001:  op_sel = ALU_SLL;
            3'b010:  op_sel = ALU_SLT;
            3'b011:  op_sel = ALU_SLTU;
            3'b100:  op_sel = ALU_XOR;
            3'b101:  op_sel = ALU_SRL;
            3'b110:  op_sel = ALU_OR;
            default: op_sel = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  op_sel = ALU_SUB;
            3'b101:  op_sel = ALU_SRA;
            default: bad    = 1'b1;
          endcase
        end else if ((funct7 == F7_MULDIV) && EN_M) begin
          case (funct3)
            3'b000:  op_sel = ALU_MUL;
            3'b001:  op_sel = ALU_MULH;
            3'b010:  op_sel = ALU_MULHSU;
            3'b011:  op_sel = ALU_MULHU;
            3'b100:  op_sel = ALU_DIV;
            3'b101:  op_sel = ALU_DIVU;
            3'b110:  op_sel = ALU_REM;
            default: op_sel = ALU_REMU;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        case (funct3)
          3'b001:  op_sel = ALU_CSRRW;
          3'b010:  op_sel = ALU_CSRRS;
          default: bad    = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  // EXU relies on a zero op code whenever the illegal flag is raised.
  assign alu_ctrl = bad ? ALU_ADD : op_sel;
  assign illegal  = bad;

endmodule

// File: rtl/alu_ctrl_decode_pipe.sv
// Registered ALU-control decode stage between IFU and EXU: 2-entry skid buffer, 1-cycle latency,
// in_ready driven only from a flop, plus a saturating counter of accepted illegal instructions.
module alu_ctrl_decode_pipe
  import npc_defs_pkg::*;
#(
  parameter bit          EN_M  = 1'b1,
  parameter int unsigned ALU_W = 5,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_alu_ctrl,
  output logic             out_illegal,
  output logic [31:0]      out_inst,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [ALU_OP_W-1:0] dec_alu;
  logic                dec_illegal;

  alu_ctrl_dec #(
    .EN_M(EN_M)
  ) u_dec (
    .opcode  (in_inst[6:0]),
    .funct3  (in_inst[14:12]),
    .funct7  (in_inst[31:25]),
    .alu_ctrl(dec_alu),
    .illegal (dec_illegal)
  );

  skid_state_e      state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [ALU_W-1:0] out_alu_q, out_alu_d;
  logic             out_ill_q, out_ill_d;
  logic [31:0]      out_inst_q, out_inst_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  logic [ALU_W-1:0] skid_alu_q, skid_alu_d;
  logic             skid_ill_q, skid_ill_d;
  logic [31:0]      skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             drain;
  logic [ALU_W-1:0] new_alu;

  assign accept  = in_valid & in_ready_q;
  assign drain   = out_valid_q & out_ready;
  assign new_alu = ALU_W'(dec_alu);

  always_comb begin
    state_d     = state_q;
    out_alu_d   = out_alu_q;
    out_ill_d   = out_ill_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    skid_alu_d  = skid_alu_q;
    skid_ill_d  = skid_ill_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    cnt_d       = cnt_q;

    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            out_alu_d  = new_alu;
            out_ill_d  = dec_illegal;
            out_inst_d = in_inst;
            out_pc_d   = in_pc;
            state_d    = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && !drain) begin
            skid_alu_d  = new_alu;
            skid_ill_d  = dec_illegal;
            skid_inst_d = in_inst;
            skid_pc_d   = in_pc;
            state_d     = SKID_FULL;
          end else if (accept && drain) begin
            out_alu_d  = new_alu;
            out_ill_d  = dec_illegal;
            out_inst_d = in_inst;
            out_pc_d   = in_pc;
          end else if (drain) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so the only event is the output register draining.
          if (drain) begin
            out_alu_d  = skid_alu_q;
            out_ill_d  = skid_ill_q;
            out_inst_d = skid_inst_q;
            out_pc_d   = skid_pc_q;
            state_d    = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase

      if (accept && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    out_valid_d = (state_d != SKID_EMPTY);
    in_ready_d  = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SKID_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_alu_q   <= '0;
      out_ill_q   <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      skid_alu_q  <= '0;
      skid_ill_q  <= 1'b0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_alu_q   <= out_alu_d;
      out_ill_q   <= out_ill_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      skid_alu_q  <= skid_alu_d;
      skid_ill_q  <= skid_ill_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_alu_ctrl = out_alu_q;
  assign out_illegal  = out_ill_q;
  assign out_inst     = out_inst_q;
  assign out_pc       = out_pc_q;
  assign illegal_cnt  = cnt_q;

endmodule
